voice_allocator: RTL

Polyphony controller for the synthesizer's oscillator bank. Scans a bitmap of held keys, detects presses and releases, and assigns each new note to one of N_VOICES oscillator voices. Per voice it drives the enable, key index and octave-down setting consumed by that voice's oscillator and note-divisor logic. When all voices are busy, the oldest voice is reallocated (compile-time option).

---
 rtl/voice_allocator.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// ---------------------------------------------------------------------------
// voice_allocator
//
// Polyphony controller for the oscillator bank. A pointer walks the held-key
// bitmap one key per cycle, comparing the live key level with the last level
// it accepted. A new press allocates a voice (lowest free index first). A new
// release frees the voice playing that key. Each event costs one extra cycle
// during which the pointer pauses on the key being serviced.
//
// Optional feature (macro VOICE_STEAL_EN):
//   defined   - a press with every voice busy takes over the oldest voice
//               (largest age, lowest index on ties) and pulses o_steal.
//   undefined - that press is discarded, voices and ages are left alone,
//               and o_drop pulses instead. o_steal is tied low.
//
// Ports:
//   clk          system clock
//   nRst         asynchronous active-low reset
//   i_keys       key-held bitmap, already synchronized and debounced
//   i_octSel     octave-down value latched into a voice when it is allocated
//   o_voiceEn    bit v enables oscillator v
//   o_voiceKey   key index of voice v at [v*KEY_W +: KEY_W]
//   o_voiceOct   octave-down of voice v at [v*2 +: 2]
//   o_steal      one-cycle pulse, an active voice was reallocated
//   o_drop       one-cycle pulse, a press found no voice and was discarded
// ---------------------------------------------------------------------------
module voice_allocator #(
    parameter int N_VOICES = 4,
    parameter int N_KEYS   = 13,
    parameter int KEY_W    = 4,
    parameter int AGE_W    = 4
) (
    input  logic                        clk,
    input  logic                        nRst,
    input  logic [N_KEYS-1:0]           i_keys,
    input  logic [1:0]                  i_octSel,
    output logic [N_VOICES-1:0]         o_voiceEn,
    output logic [N_VOICES*KEY_W-1:0]   o_voiceKey,
    output logic [N_VOICES*2-1:0]       o_voiceOct,
    output logic                        o_steal,
    output logic                        o_drop
);

    localparam int VIDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(N_KEYS - 1);

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        ALLOC   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                           r_state;
    state_t                           w_nextState;
    logic [KEY_W-1:0]                 r_ptr;
    logic [N_KEYS-1:0]                r_held;
    logic [N_VOICES-1:0]              r_voiceEn;
    logic [N_VOICES-1:0][KEY_W-1:0]   r_voiceKey;
    logic [N_VOICES-1:0][1:0]         r_voiceOct;
    logic                             r_noVoice;

    logic                             w_keyNow;
    logic                             w_heldNow;
    logic                             w_advance;
    logic [KEY_W-1:0]                 w_ptrNext;
    logic                             w_hasFree;
    logic [VIDX_W-1:0]                w_freeIdx;
    logic [VIDX_W-1:0]                w_target;
    logic                             w_doWrite;

`ifdef VOICE_STEAL_EN
    // Ages only exist to pick a victim, so they are kept only when
    // stealing is built in.
    logic [N_VOICES-1:0][AGE_W-1:0]   r_age;
    logic [VIDX_W-1:0]                w_oldIdx;
    logic [AGE_W-1:0]                 w_oldAge;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
`endif

    assign w_keyNow  = i_keys[r_ptr];
    assign w_heldNow = r_held[r_ptr];
    assign w_ptrNext = (r_ptr == LAST_KEY) ? '0 : r_ptr + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state. The pointer stays put while an event on its key is serviced
    // so that ALLOC/RELEASE still address that key.
    always_comb begin
        w_nextState = r_state;
        w_advance   = 1'b0;
        case (r_state)
            SCAN: begin
                if (w_keyNow && !w_heldNow) begin
                    w_nextState = ALLOC;
                end else if (!w_keyNow && w_heldNow) begin
                    w_nextState = RELEASE;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ALLOC, RELEASE: begin
                w_nextState = SCAN;
                w_advance   = 1'b1;
            end
            default: begin
                w_nextState = SCAN;
            end
        endcase
    end

    // Scan pointer and accepted key levels.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_ptr  <= '0;
            r_held <= '0;
        end else begin
            if (w_advance) begin
                r_ptr <= w_ptrNext;
            end
            if (r_state == ALLOC) begin
                r_held[r_ptr] <= 1'b1;
            end else if (r_state == RELEASE) begin
                r_held[r_ptr] <= 1'b0;
            end
        end
    end

    // Lowest-index idle voice: scanning downward lets the lowest hit win.
    always_comb begin
        w_hasFree = 1'b0;
        w_freeIdx = '0;
        for (int v = N_VOICES - 1; v >= 0; v--) begin
            if (!r_voiceEn[v]) begin
                w_hasFree = 1'b1;
                w_freeIdx = VIDX_W'(v);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    // Oldest voice; strict greater-than keeps the lowest index on ties.
    // Only consulted when every voice is enabled.
    always_comb begin
        w_oldIdx = '0;
        w_oldAge = r_age[0];
        for (int v = 1; v < N_VOICES; v++) begin
            if (r_age[v] > w_oldAge) begin
                w_oldIdx = VIDX_W'(v);
                w_oldAge = r_age[v];
            end
        end
    end

    assign w_target  = w_hasFree ? w_freeIdx : w_oldIdx;
    assign w_doWrite = (r_state == ALLOC);
`else
    assign w_target  = w_freeIdx;
    assign w_doWrite = (r_state == ALLOC) && w_hasFree;
`endif

    // Voice table. A press writes the target and ages the others; a release
    // clears only the enable so the oscillator's key/octave stay stable.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_voiceEn  <= '0;
            r_voiceKey <= '0;
            r_voiceOct <= '0;
            r_noVoice  <= 1'b0;
`ifdef VOICE_STEAL_EN
            r_age      <= '0;
`endif
        end else begin
            r_noVoice <= (r_state == ALLOC) && !w_hasFree;
            if (w_doWrite) begin
                for (int v = 0; v < N_VOICES; v++) begin
                    if (VIDX_W'(v) == w_target) begin
                        r_voiceEn[v]  <= 1'b1;
                        r_voiceKey[v] <= r_ptr;
                        r_voiceOct[v] <= i_octSel;
`ifdef VOICE_STEAL_EN
                        r_age[v]      <= '0;
                    end else if (r_voiceEn[v] && (r_age[v] != AGE_MAX)) begin
                        r_age[v]      <= r_age[v] + 1'b1;
`endif
                    end
                end
            end else if (r_state == RELEASE) begin
                for (int v = 0; v < N_VOICES; v++) begin
                    if (r_voiceEn[v] && (r_voiceKey[v] == r_ptr)) begin
                        r_voiceEn[v] <= 1'b0;
`ifdef VOICE_STEAL_EN
                        r_age[v]     <= '0;
`endif
                    end
                end
            end
        end
    end

    assign o_voiceEn  = r_voiceEn;
    assign o_voiceKey = r_voiceKey;
    assign o_voiceOct = r_voiceOct;

`ifdef VOICE_STEAL_EN
    assign o_steal = r_noVoice;
    assign o_drop  = 1'b0;
`else
    assign o_steal = 1'b0;
    assign o_drop  = r_noVoice;
`endif

endmodule
